// File: rtl/hdmi_rd_pkg.sv
// Shared types for the HDMI frame reader: FSM states, AXI constants,
// and the XRGB pixel layout.
package hdmi_rd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DATA,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

   typedef struct packed {
      logic [7:0] pad;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/hdmi_rd_fifo.sv
// Synchronous pixel FIFO; head word is visible on dout while not empty.
// Depth must be a power of two.
module hdmi_rd_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == (AW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign count  = r_count;
   assign dout   = r_mem[r_rd];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/hdmi_frame_reader.sv
// AXI4 read master fetching one frame in INCR bursts into a pixel stream.
// HDMI_RD_CONTINUOUS_EN: restart automatically after each frame.
module hdmi_frame_reader
   import hdmi_rd_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_BURST_LEN  = 8,
   parameter int H_ACTIVE           = 1280,
   parameter int V_ACTIVE           = 720,
   parameter int FIFO_DEPTH         = 64
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          INIT_AXI_TXN,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] FRAME_BASE,
   output logic                          TXN_DONE,
   output logic                          ERROR,
   output logic                          M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic [31:0]                   PIX_TDATA,
   output logic                          PIX_TVALID,
   input  logic                          PIX_TREADY,
   output logic                          PIX_TUSER,
   output logic                          PIX_TLAST
);

   localparam int NBURST = H_ACTIVE * V_ACTIVE / C_M_AXI_BURST_LEN;
   localparam int BW     = $clog2(NBURST) + 1;
   localparam int BTW    = $clog2(C_M_AXI_BURST_LEN);
   localparam int CW     = $clog2(FIFO_DEPTH) + 1;
   localparam int XW     = $clog2(H_ACTIVE) + 1;
   localparam int YW     = $clog2(V_ACTIVE) + 1;
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
      C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * 4);

   state_t                        r_state;
   state_t                        w_next;
   logic                          r_init;
   logic                          r_init_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
   logic [BW-1:0]                 r_burst;
   logic [BTW-1:0]                r_beat;
   logic                          r_error;
   logic [XW-1:0]                 r_x;
   logic [YW-1:0]                 r_y;

   logic          w_rise;
   logic          w_start;
   logic          w_ar_hs;
   logic          w_r_hs;
   logic          w_last_beat;
   logic          w_last_burst;
   logic          w_space_ok;
   logic          w_pop;
   logic          w_empty;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_free;
   logic [31:0]   w_head;
   pixel_t        w_pix_in;
   logic          w_unused;

   assign w_rise       = r_init & ~r_init_q;
   assign w_free       = CW'(FIFO_DEPTH) - w_count;
   assign w_space_ok   = (w_free >= CW'(C_M_AXI_BURST_LEN));
   assign w_ar_hs      = M_AXI_ARVALID & M_AXI_ARREADY;
   assign w_r_hs       = M_AXI_RVALID & M_AXI_RREADY;
   assign w_last_beat  = (r_beat == BTW'(C_M_AXI_BURST_LEN - 1));
   assign w_last_burst = (r_burst == BW'(NBURST - 1));
   assign w_pop        = ~w_empty & PIX_TREADY;
   assign w_start      = (w_next == S_REQ) &&
                         (r_state == S_IDLE || r_state == S_DONE);

   assign M_AXI_ARID    = 1'b0;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
   assign M_AXI_ARSIZE  = AXI_SIZE_4B;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARCACHE = AXI_CACHE_BUF;
   assign M_AXI_ARPROT  = 3'b000;
   // Space only grows while in REQ, so ARVALID cannot drop before ARREADY.
   assign M_AXI_ARVALID = (r_state == S_REQ) & w_space_ok;
   assign M_AXI_RREADY  = (r_state == S_DATA);

   assign TXN_DONE   = (r_state == S_DONE);
   assign ERROR      = r_error;
   assign PIX_TDATA  = w_head;
   assign PIX_TVALID = ~w_empty;
   assign PIX_TUSER  = (r_x == '0) && (r_y == '0);
   assign PIX_TLAST  = (r_x == XW'(H_ACTIVE - 1));

   assign w_pix_in = '{pad: 8'h00,
                       r:   M_AXI_RDATA[23:16],
                       g:   M_AXI_RDATA[15:8],
                       b:   M_AXI_RDATA[7:0]};
   assign w_unused = &{1'b0, M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:24], w_full};

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_rise) w_next = S_REQ;
         S_REQ:   if (w_ar_hs) w_next = S_DATA;
         S_DATA:  if (w_r_hs && w_last_beat)
                     w_next = w_last_burst ? S_DRAIN : S_REQ;
         S_DRAIN: if (w_empty) w_next = S_DONE;
`ifdef HDMI_RD_CONTINUOUS_EN
         S_DONE:  w_next = S_REQ;
`else
         S_DONE:  if (w_rise) w_next = S_REQ;
`endif
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) r_state <= S_IDLE;
      else                r_state <= w_next;
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         r_init   <= 1'b0;
         r_init_q <= 1'b0;
         r_addr   <= '0;
         r_burst  <= '0;
         r_beat   <= '0;
         r_error  <= 1'b0;
      end else begin
         r_init   <= INIT_AXI_TXN;
         r_init_q <= r_init;
         if (w_start) begin
            r_addr  <= FRAME_BASE;
            r_burst <= '0;
            r_beat  <= '0;
            r_error <= 1'b0;
         end else begin
            if (w_ar_hs) r_addr <= r_addr + BURST_BYTES;
            if (w_r_hs) begin
               r_beat <= r_beat + BTW'(1);
               if (w_last_beat) r_burst <= r_burst + BW'(1);
               if (M_AXI_RRESP != AXI_RESP_OKAY || M_AXI_RLAST != w_last_beat)
                  r_error <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_pop) begin
         if (r_x == XW'(H_ACTIVE - 1)) begin
            r_x <= '0;
            r_y <= (r_y == YW'(V_ACTIVE - 1)) ? '0 : r_y + YW'(1);
         end else begin
            r_x <= r_x + XW'(1);
         end
      end
   end

   hdmi_rd_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (M_AXI_ACLK),
      .rst_n (M_AXI_ARESETN),
      .push  (w_r_hs),
      .pop   (w_pop),
      .din   (w_pix_in),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Bench for hdmi_frame_reader: random AXI slave memory (word = addr>>2),
// random sink backpressure, pixel stream checked against address arithmetic.
module tb_hdmi_frame_reader;

   localparam int H  = 16;
   localparam int V  = 2;
   localparam int BL = 8;
   localparam int NP = H * V;
   localparam int NB = NP / BL;

   logic        clk = 1'b0;
   logic        M_AXI_ARESETN;
   logic        INIT_AXI_TXN;
   logic [31:0] FRAME_BASE;
   logic        TXN_DONE, ERROR;
   logic        M_AXI_ARID;
   logic [31:0] M_AXI_ARADDR;
   logic [7:0]  M_AXI_ARLEN;
   logic [2:0]  M_AXI_ARSIZE;
   logic [1:0]  M_AXI_ARBURST;
   logic [3:0]  M_AXI_ARCACHE;
   logic [2:0]  M_AXI_ARPROT;
   logic        M_AXI_ARVALID, M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
   logic [31:0] PIX_TDATA;
   logic        PIX_TVALID, PIX_TREADY, PIX_TUSER, PIX_TLAST;

   always #5 clk = ~clk;

   hdmi_frame_reader #(
      .C_M_AXI_ADDR_WIDTH (32),
      .C_M_AXI_DATA_WIDTH (32),
      .C_M_AXI_BURST_LEN  (BL),
      .H_ACTIVE           (H),
      .V_ACTIVE           (V),
      .FIFO_DEPTH         (16)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (M_AXI_ARESETN),
      .INIT_AXI_TXN  (INIT_AXI_TXN),
      .FRAME_BASE    (FRAME_BASE),
      .TXN_DONE      (TXN_DONE),
      .ERROR         (ERROR),
      .M_AXI_ARID    (M_AXI_ARID),
      .M_AXI_ARADDR  (M_AXI_ARADDR),
      .M_AXI_ARLEN   (M_AXI_ARLEN),
      .M_AXI_ARSIZE  (M_AXI_ARSIZE),
      .M_AXI_ARBURST (M_AXI_ARBURST),
      .M_AXI_ARCACHE (M_AXI_ARCACHE),
      .M_AXI_ARPROT  (M_AXI_ARPROT),
      .M_AXI_ARVALID (M_AXI_ARVALID),
      .M_AXI_ARREADY (M_AXI_ARREADY),
      .M_AXI_RDATA   (M_AXI_RDATA),
      .M_AXI_RRESP   (M_AXI_RRESP),
      .M_AXI_RLAST   (M_AXI_RLAST),
      .M_AXI_RVALID  (M_AXI_RVALID),
      .M_AXI_RREADY  (M_AXI_RREADY),
      .PIX_TDATA     (PIX_TDATA),
      .PIX_TVALID    (PIX_TVALID),
      .PIX_TREADY    (PIX_TREADY),
      .PIX_TUSER     (PIX_TUSER),
      .PIX_TLAST     (PIX_TLAST)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference state shared with the stimulus process
   logic [31:0] exp_base = 32'h1000_0000;
   int pix_cnt = 0;
   int ar_cnt  = 0;
   int rdy_mode = 2;
   int err_burst = 99, err_beat = 0;
   int last_burst = 99, last_beat = 0;

   // AXI slave memory and pixel sink, all driven on the falling edge
   initial begin
      logic [31:0] arq[$];
      logic [31:0] addr, bidx, expd;
      int beat, k;
      bit rv;
      beat = 0;
      rv = 0;
      M_AXI_ARREADY = 0;
      M_AXI_RVALID  = 0;
      M_AXI_RDATA   = 0;
      M_AXI_RRESP   = 0;
      M_AXI_RLAST   = 0;
      PIX_TREADY    = 0;
      forever begin
         @(negedge clk);
         if (!M_AXI_ARESETN) begin
            arq.delete();
            beat = 0;
            rv = 0;
            M_AXI_RVALID  = 0;
            M_AXI_RLAST   = 0;
            M_AXI_ARREADY = 0;
            PIX_TREADY    = 0;
         end else begin
            if (!rv && arq.size() > 0) rv = ($urandom_range(0, 3) != 0);
            M_AXI_RVALID = rv;
            if (rv) begin
               addr = arq[0] + 32'(beat * 4);
               bidx = (arq[0] - exp_base) >> 5;
               M_AXI_RDATA = addr >> 2;
               M_AXI_RRESP = (bidx == 32'(err_burst) && beat == err_beat)
                             ? 2'b10 : 2'b00;
               M_AXI_RLAST = (beat == BL - 1) ||
                             (bidx == 32'(last_burst) && beat == last_beat);
            end else begin
               M_AXI_RDATA = $urandom;
               M_AXI_RRESP = 2'b00;
               M_AXI_RLAST = 1'b0;
            end
            if (rv && M_AXI_RREADY) begin
               beat++;
               rv = 0;
               if (beat == BL) begin
                  beat = 0;
                  void'(arq.pop_front());
               end
            end
            M_AXI_ARREADY = ($urandom_range(0, 2) != 0);
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               chk("araddr", M_AXI_ARADDR, exp_base + 32'((ar_cnt % NB) * BL * 4));
               chk("ar_attr",
                   {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
                    M_AXI_ARCACHE, M_AXI_ARPROT},
                   {1'b0, 8'd7, 3'b010, 2'b01, 4'b0011, 3'b000});
               arq.push_back(M_AXI_ARADDR);
               ar_cnt++;
            end
            case (rdy_mode)
               0:       PIX_TREADY = 1'b0;
               1:       PIX_TREADY = ($urandom_range(0, 1) != 0);
               default: PIX_TREADY = 1'b1;
            endcase
            if (PIX_TVALID && PIX_TREADY) begin
               k = pix_cnt % NP;
               expd = (exp_base + 32'(k * 4)) >> 2;
               chk("pixel", {PIX_TUSER, PIX_TLAST, PIX_TDATA},
                   {k == 0, (k % H) == H - 1, 8'h00, expd[23:0]});
               pix_cnt++;
            end
         end
      end
   end

   task automatic start_frame(input logic [31:0] base);
      exp_base = base;
      pix_cnt = 0;
      ar_cnt = 0;
      FRAME_BASE = base;
      @(negedge clk);
      INIT_AXI_TXN = 1'b1;
      @(negedge clk);
      INIT_AXI_TXN = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("start_clears", {TXN_DONE, ERROR}, 2'b00);
   endtask

   task automatic wait_done(input logic exp_err);
      int c;
      c = 0;
      while (!TXN_DONE && c < 4000) begin
         @(negedge clk);
         c++;
      end
      chk("done_seen", TXN_DONE, 1'b1);
      chk("pix_count", pix_cnt, NP);
      chk("ar_count", ar_cnt, NB);
      chk("error_flag", ERROR, exp_err);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 M_AXI_ARESETN = 1'b0;
      @(posedge clk);
      #1 M_AXI_ARESETN = 1'b1;
      @(negedge clk);
      chk("reset_outs",
          {M_AXI_ARVALID, M_AXI_RREADY, TXN_DONE, ERROR, PIX_TVALID}, 5'b0);
   endtask

   initial begin
      int c;
      M_AXI_ARESETN = 1'b0;
      INIT_AXI_TXN  = 1'b0;
      FRAME_BASE    = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs",
          {M_AXI_ARVALID, M_AXI_RREADY, TXN_DONE, ERROR, PIX_TVALID}, 5'b0);
      @(posedge clk);
      #1 M_AXI_ARESETN = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_req", {M_AXI_ARVALID, TXN_DONE}, 2'b00);
`ifdef HDMI_RD_CONTINUOUS_EN
      rdy_mode = 1;
      start_frame(32'h1000_0000);
      c = 0;
      k_loop: for (int p = 0; p < 3; ) begin
         @(negedge clk);
         c++;
         if (c > 8000) break;
         if (TXN_DONE) begin
            p++;
            chk("frame_pixels", pix_cnt, NP * p);
            chk("frame_error", ERROR, 1'b0);
         end
      end
      chk("three_frames", pix_cnt >= 3 * NP, 1'b1);
      pulse_reset();
`else
      // clean frame
      rdy_mode = 1;
      start_frame(32'h1000_0000);
      wait_done(1'b0);
      repeat (4) @(negedge clk);
      chk("done_holds", TXN_DONE, 1'b1);

      // sink stalled: only the FIFO's worth of bursts may be fetched
      rdy_mode = 0;
      start_frame(32'h1000_0000);
      repeat (100) @(negedge clk);
      chk("stall_ar_count", ar_cnt, 2);
      chk("stall_tvalid", PIX_TVALID, 1'b1);
      chk("stall_pixels", pix_cnt, 0);
      rdy_mode = 1;
      wait_done(1'b0);

      // SLVERR on burst 1 beat 3
      err_burst = 1;
      err_beat = 3;
      start_frame(32'h2000_0400);
      wait_done(1'b1);
      repeat (5) @(negedge clk);
      chk("error_sticky", ERROR, 1'b1);
      err_burst = 99;

      // early RLAST on beat 5, then a clean frame clears ERROR
      last_burst = 0;
      last_beat = 5;
      rdy_mode = 2;
      start_frame(32'h1000_0000);
      wait_done(1'b1);
      last_burst = 99;
      start_frame(32'h1000_0000);
      wait_done(1'b0);

      // reset during burst 2, then a fresh frame from base
      rdy_mode = 1;
      start_frame(32'h1000_0000);
      c = 0;
      while (ar_cnt < 3 && c < 2000) begin
         @(posedge clk);
         c++;
      end
      chk("burst2_reached", ar_cnt >= 3, 1'b1);
      pulse_reset();
      start_frame(32'h1000_0000);
      wait_done(1'b0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
